// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants and FSM state encoding for the single-wire I2C master.
package i2c_pkg;

   localparam int unsigned ADDR_W   = 7;
   localparam int unsigned DATA_W   = 8;
   localparam logic        RW_WRITE = 1'b0;
   localparam logic        RW_READ  = 1'b1;
   localparam logic        ACK      = 1'b0;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W,
      RSTART, ADDR2, ACK_A2, RDATA, MNACK, STOP, DONE
   } state_t;

endpackage

// File: rtl/i2c_bit_shifter.sv
// i2c_bit_shifter: field register with parallel load, MSB-first shift-out/shift-in and a
// bit counter that wraps naturally at the end of each field.
module i2c_bit_shifter #(
   parameter int unsigned W     = i2c_pkg::DATA_W,
   parameter int unsigned CNT_W = $clog2(W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [W-1:0]     load_data,
   input  logic             shift,
   input  logic             step,
   input  logic             clr,
   input  logic             sin,
   output logic             msb,
   output logic [W-1:0]     data,
   output logic [CNT_W-1:0] cnt,
   output logic             last_bit
);

   logic [W-1:0]     sr_q;
   logic [CNT_W-1:0] cnt_q;

   // Shift register and bit counter; load/clr restart the count at bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (load) begin
            sr_q <= load_data;
         end else if (shift) begin
            sr_q <= {sr_q[W-2:0], sin};
         end
         if (load || clr) begin
            cnt_q <= '0;
         end else if (shift || step) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign msb      = sr_q[W-1];
   assign data     = sr_q;
   assign cnt      = cnt_q;
   assign last_bit = (cnt_q == CNT_W'(W - 1));

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-wire, one-bit-per-clk I2C master for register write/read.
// Optional: define I2C_MASTER_RETRY_EN to restart a NACKed transaction up to MAX_RETRY times.
module i2c_master_ctrl #(
   parameter int unsigned ADDR_W    = i2c_pkg::ADDR_W,
   parameter int unsigned DATA_W    = i2c_pkg::DATA_W,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_reg,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_nack,
   output logic              busy,
   inout  wire               sda
);
   import i2c_pkg::*;

`ifdef I2C_MASTER_RETRY_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif
   localparam int unsigned CNT_W  = $clog2(DATA_W);
   localparam int unsigned RCNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   state_t              state_q, state_d;
   logic                rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   reg_q, wdata_q, resp_rdata_q;
   logic                nack_q, resp_nack_q;
   logic [RCNT_W-1:0]   retry_q;
   logic                retry_ok, set_nack, retry_go, ack_seen;
   logic                sda_oe, sda_out;
   logic                sh_load, sh_shift, sh_step, sh_clr, sh_msb, sh_last;
   logic [DATA_W-1:0]   sh_ld, sh_data;
   logic [CNT_W-1:0]    sh_cnt;

   // Only a driven low counts as ACK; released (z) or high reads as NACK.
   assign ack_seen = (sda == ACK);
   assign retry_ok = RETRY_ON && (32'(retry_q) < MAX_RETRY);

   i2c_bit_shifter #(
      .W     (DATA_W),
      .CNT_W (CNT_W)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (sh_load),
      .load_data (sh_ld),
      .shift     (sh_shift),
      .step      (sh_step),
      .clr       (sh_clr),
      .sin       (sda),
      .msb       (sh_msb),
      .data      (sh_data),
      .cnt       (sh_cnt),
      .last_bit  (sh_last)
   );

   // Next-state, sda drive and shifter control for each bus phase.
   always_comb begin
      state_d  = state_q;
      sda_oe   = 1'b0;
      sda_out  = 1'b1;
      sh_load  = 1'b0;
      sh_ld    = '0;
      sh_shift = 1'b0;
      sh_step  = 1'b0;
      sh_clr   = 1'b0;
      set_nack = 1'b0;
      retry_go = 1'b0;
      unique case (state_q)
         IDLE: begin
            sh_clr = 1'b1;
            if (cmd_valid) state_d = START;
         end
         START: begin
            sda_oe  = 1'b1;
            sda_out = 1'b0;
            sh_load = 1'b1;
            sh_ld   = {addr_q, RW_WRITE};
            state_d = ADDR;
         end
         ADDR, REG, WDATA, ADDR2: begin
            sda_oe   = 1'b1;
            sda_out  = sh_msb;
            sh_shift = 1'b1;
            if (sh_last) begin
               unique case (state_q)
                  ADDR:    state_d = ACK_A;
                  REG:     state_d = ACK_R;
                  WDATA:   state_d = ACK_W;
                  default: state_d = ACK_A2;
               endcase
            end
         end
         ACK_A: begin
            sh_clr = 1'b1;
            if (ack_seen) begin
               sh_load = 1'b1;
               sh_ld   = reg_q;
               state_d = REG;
            end else begin
               set_nack = 1'b1;
               state_d  = STOP;
            end
         end
         ACK_R: begin
            sh_clr = 1'b1;
            if (!ack_seen) begin
               set_nack = 1'b1;
               state_d  = STOP;
            end else if (rw_q == RW_READ) begin
               state_d = RSTART;
            end else begin
               sh_load = 1'b1;
               sh_ld   = wdata_q;
               state_d = WDATA;
            end
         end
         ACK_W: begin
            sh_clr   = 1'b1;
            set_nack = !ack_seen;
            state_d  = STOP;
         end
         RSTART: begin
            // Repeated start: high for one cycle, then low.
            sda_oe  = 1'b1;
            sda_out = (sh_cnt == CNT_W'(0));
            sh_step = 1'b1;
            if (sh_cnt == CNT_W'(1)) begin
               sh_load = 1'b1;
               sh_ld   = {addr_q, RW_READ};
               state_d = ADDR2;
            end
         end
         ACK_A2: begin
            sh_clr = 1'b1;
            if (ack_seen) begin
               state_d = RDATA;
            end else begin
               set_nack = 1'b1;
               state_d  = STOP;
            end
         end
         RDATA: begin
            sh_shift = 1'b1;
            if (sh_last) state_d = MNACK;
         end
         MNACK: begin
            sda_oe  = 1'b1;
            sda_out = 1'b1;
            sh_clr  = 1'b1;
            state_d = STOP;
         end
         STOP: begin
            // Low then high; a retried attempt adds one released cycle before START.
            sh_step = 1'b1;
            if (sh_cnt == CNT_W'(0)) begin
               sda_oe  = 1'b1;
               sda_out = 1'b0;
            end else if (sh_cnt == CNT_W'(1)) begin
               sda_oe  = 1'b1;
               sda_out = 1'b1;
               if (!(nack_q && retry_ok)) state_d = DONE;
            end else begin
               retry_go = 1'b1;
               state_d  = START;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, latched command, NACK/retry tracking and the response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rw_q         <= RW_WRITE;
         addr_q       <= '0;
         reg_q        <= '0;
         wdata_q      <= '0;
         nack_q       <= 1'b0;
         retry_q      <= '0;
         resp_rdata_q <= '0;
         resp_nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && cmd_valid) begin
            rw_q    <= cmd_rw;
            addr_q  <= cmd_addr;
            reg_q   <= cmd_reg;
            wdata_q <= cmd_wdata;
            nack_q  <= 1'b0;
            retry_q <= '0;
         end
         if (set_nack) nack_q <= 1'b1;
         if (retry_go) begin
            nack_q  <= 1'b0;
            retry_q <= retry_q + 1'b1;
         end
         if (state_d == DONE) begin
            resp_nack_q  <= nack_q;
            resp_rdata_q <= (rw_q == RW_READ && !nack_q) ? sh_data : '0;
         end
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign resp_valid = (state_q == DONE);
   assign resp_rdata = resp_rdata_q;
   assign resp_nack  = resp_nack_q;
   assign sda        = sda_oe ? sda_out : 1'bz;

endmodule
